// File: rtl/digit_serial_addsub.sv
// Multi-digit add/subtract built around a 4-bit slice: one digit per clock, LS digit first.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+NDIGITS.
// Backpressure: start is ignored while busy; back-to-back issue is one op per NDIGITS+1 cycles.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset (reset wins over everything)
//   start             : request pulse, accepted only when busy=0
//   opa, opb, subtract: operands and op select, sampled on the accepted start edge
//   busy, done        : busy while digits are being processed; done is a one-cycle pulse
//   result, cout      : registered W-bit result and carry out (subtract: 1 = no borrow)
//   overflow          : two's-complement overflow of the W-bit operation
module digit_serial_addsub #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   opa,
  input  logic [4*NDIGITS-1:0]   opb,
  input  logic                   subtract,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   result,
  output logic                   cout,
  output logic                   overflow
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, work_q, work_nxt;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            last;
  logic [3:0]      a_dig, b_dig;
  logic [4:0]      sum;
  logic            c3;

  // ---------------------------------------------------------------
  // Digit slice
  // ---------------------------------------------------------------
  always_comb begin
    a_dig    = '0;
    b_dig    = '0;
    work_nxt = work_q;
    for (int d = 0; d < NDIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        a_dig = a_q[4*d +: 4];
        b_dig = b_q[4*d +: 4];
      end
    end
    // Full 5-bit sum so the digit carry is never lost to truncation.
    sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    // Carry into bit 3 recovered from the sum bit: s3 = a3 ^ b3 ^ c3.
    c3  = sum[3] ^ a_dig[3] ^ b_dig[3];
    for (int d = 0; d < NDIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        work_nxt[4*d +: 4] = sum[3:0];
      end
    end
  end

  assign last = (idx_q == IW'(NDIGITS - 1));

  // ---------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // ---------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= opa;
            // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
            b_q     <= subtract ? ~opb : opb;
            carry_q <= subtract;
            idx_q   <= '0;
          end
        end
        RUN: begin
          work_q  <= work_nxt;
          carry_q <= sum[4];
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            result   <= work_nxt;
            cout     <= sum[4];
            overflow <= c3 ^ sum[4];
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // NDIGITS=4 instance
  logic        start4, sub4, busy4, done4, cout4, ovf4;
  logic [15:0] opa4, opb4, res4;
  // NDIGITS=1 instance
  logic        start1, sub1, busy1, done1, cout1, ovf1;
  logic [3:0]  opa1, opb1, res1;

  digit_serial_addsub #(.NDIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .opa(opa4), .opb(opb4),
    .subtract(sub4), .busy(busy4), .done(done4), .result(res4),
    .cout(cout4), .overflow(ovf4)
  );

  digit_serial_addsub #(.NDIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .opa(opa1), .opb(opb1),
    .subtract(sub1), .busy(busy1), .done(done1), .result(res1),
    .cout(cout1), .overflow(ovf1)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: W-bit A +/- B with carry and signed overflow.
  function automatic void calc(input int w, input logic [15:0] a, input logic [15:0] b,
                               input logic s, output logic [15:0] r,
                               output logic c, output logic v);
    logic [16:0] mask, bb, full;
    mask = (17'd1 << w) - 17'd1;
    bb   = s ? ((~{1'b0, b}) & mask) : {1'b0, b};
    full = {1'b0, a} + bb + {16'd0, s};
    r    = full[15:0] & mask[15:0];
    c    = full[w];
    v    = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
  endfunction

  // Transaction-level models: an accepted op completes N cycles later.
  int          m4_left, m1_left;
  logic        m4_done, m4_c, m4_v, p4_c, p4_v;
  logic [15:0] m4_res, p4_res;
  logic        m1_done, m1_c, m1_v, p1_c, p1_v;
  logic [15:0] m1_res, p1_res;

  always @(posedge clk) begin
    if (reset) begin
      m4_left = 0; m4_done = 0; m4_res = 0; m4_c = 0; m4_v = 0;
    end else begin
      m4_done = 0;
      if (m4_left > 0) begin
        m4_left--;
        if (m4_left == 0) begin
          m4_res = p4_res; m4_c = p4_c; m4_v = p4_v; m4_done = 1;
        end
      end else if (start4) begin
        calc(16, opa4, opb4, sub4, p4_res, p4_c, p4_v);
        m4_left = 4;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m1_left = 0; m1_done = 0; m1_res = 0; m1_c = 0; m1_v = 0;
    end else begin
      m1_done = 0;
      if (m1_left > 0) begin
        m1_left--;
        if (m1_left == 0) begin
          m1_res = p1_res; m1_c = p1_c; m1_v = p1_v; m1_done = 1;
        end
      end else if (start1) begin
        calc(4, {12'd0, opa1}, {12'd0, opb1}, sub1, p1_res, p1_c, p1_v);
        m1_left = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy4", {15'd0, busy4}, {15'd0, (m4_left > 0)});
      chk("done4", {15'd0, done4}, {15'd0, m4_done});
      chk("res4",  res4, m4_res);
      chk("cout4", {15'd0, cout4}, {15'd0, m4_c});
      chk("ovf4",  {15'd0, ovf4},  {15'd0, m4_v});
      chk("busy1", {15'd0, busy1}, {15'd0, (m1_left > 0)});
      chk("done1", {15'd0, done1}, {15'd0, m1_done});
      chk("res1",  {12'd0, res1}, m1_res);
      chk("cout1", {15'd0, cout1}, {15'd0, m1_c});
      chk("ovf1",  {15'd0, ovf1},  {15'd0, m1_v});
    end
  end

  task automatic run4(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [15:0] er, input logic ec, input logic ev);
    int nb = 0;
    bit seen = 0;
    @(negedge clk);
    opa4 = a; opb4 = b; sub4 = s; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (busy4) nb++;
      if (done4) begin
        seen = 1;
        chk({name, "_done_cycle"}, 16'(k), 16'd5);
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, {15'd0, seen}, 16'd1);
    chk({name, "_busy_cycles"}, 16'(nb), 16'd4);
    chk({name, "_result"}, res4, er);
    chk({name, "_cout"}, {15'd0, cout4}, {15'd0, ec});
    chk({name, "_ovf"}, {15'd0, ovf4}, {15'd0, ev});
  endtask

  task automatic run1(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic s, input logic [3:0] er, input logic ec, input logic ev);
    int nb = 0;
    bit seen = 0;
    @(negedge clk);
    opa1 = a; opb1 = b; sub1 = s; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (busy1) nb++;
      if (done1) begin
        seen = 1;
        chk({name, "_done_cycle"}, 16'(k), 16'd2);
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, {15'd0, seen}, 16'd1);
    chk({name, "_busy_cycles"}, 16'(nb), 16'd1);
    chk({name, "_result"}, {12'd0, res1}, {12'd0, er});
    chk({name, "_cout"}, {15'd0, cout1}, {15'd0, ec});
    chk({name, "_ovf"}, {15'd0, ovf1}, {15'd0, ev});
  endtask

  initial begin
    int d1, d2;
    bit seen;
    reset = 1'b1;
    start4 = 0; sub4 = 0; opa4 = '0; opb4 = '0;
    start1 = 0; sub1 = 0; opa1 = '0; opb1 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {15'd0, busy4}, 16'd0);
    chk("rst_done", {15'd0, done4}, 16'd0);
    chk("rst_res",  res4, 16'h0000);
    reset = 1'b0;

    run4("add",      16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    run4("sub_neg",  16'h1234, 16'h1235, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run4("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run4("add_sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run4("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    run1("n1_sub",   4'h9, 4'h7, 1'b1, 4'h2, 1'b1, 1'b1);
    run1("n1_add",   4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0);
    run1("n1_sovf",  4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

    // Start held high through RUN, operands disturbed mid-run, second op
    // issued in the done cycle.
    d1 = 0; d2 = 0;
    @(negedge clk);
    opa4 = 16'h1111; opb4 = 16'h2222; sub4 = 1'b0; start4 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) begin
        opa4 = 16'hFFFF; opb4 = 16'hFFFF; sub4 = 1'b1;
      end
      if (done4) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
      if (k == 5) begin
        chk("b2b_res1", res4, 16'h3333);
        opa4 = 16'h0003; opb4 = 16'h0004; sub4 = 1'b1;
      end
      if (k >= 6 && k <= 9) chk("b2b_hold", res4, 16'h3333);
      if (k == 10) begin
        chk("b2b_res2", res4, 16'hFFFF);
        chk("b2b_cout2", {15'd0, cout4}, 16'd0);
        start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    chk("b2b_done1_cycle", 16'(d1), 16'd5);
    chk("b2b_done2_cycle", 16'(d2), 16'd10);

    // Reset on the second RUN cycle discards the op.
    @(negedge clk);
    opa4 = 16'h1234; opb4 = 16'h1111; sub4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", {15'd0, busy4}, 16'd0);
    chk("rstmid_done", {15'd0, done4}, 16'd0);
    chk("rstmid_res",  res4, 16'h0000);
    chk("rstmid_cout", {15'd0, cout4}, 16'd0);
    chk("rstmid_ovf",  {15'd0, ovf4}, 16'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    chk("rstmid_no_done", {15'd0, seen}, 16'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Multi-digit add/subtract engine that sits around our 4-bit add/subtract slice.
- Accepts two W-bit operands, W = 4*NDIGITS, and processes them one 4-bit digit per clock, least-significant digit first.
- Ripples the slice carry between digits through a carry register.
- Delivers a registered W-bit result with carry-out and signed overflow, under a Start/Busy/Done handshake.

Parameters:
- NDIGITS, 4, number of 4-bit digits; operand width W = 4*NDIGITS; legal range 1..16.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request pulse; sampled only when Busy=0.
- OpA  input  W  operand A, sampled on the accepted Start edge.
- OpB  input  W  operand B, sampled on the accepted Start edge.
- Subtract  input  1  0: A+B; 1: A-B. Sampled on the accepted Start edge.
- Busy  output  1  high while digits are being processed.
- Done  output  1  one-cycle completion pulse.
- Result  output  W  sum/difference; updated only at completion.
- Cout  output  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned).
- Overflow  output  1  two's-complement overflow of the W-bit operation.

Behaviour:
- Clocking and reset:
  - One clock, Clk. Reset is synchronous and active-high.
  - Reset has priority over every other input at any time, including mid-operation.
  - On Reset: state=IDLE; Busy, Done, Result, Cout, Overflow all 0; digit counter 0; carry 0; the in-flight operation is discarded.
- States: IDLE, RUN.
- IDLE, Start=1 at edge E0 (accept):
  - latch OpA into a working A register;
  - latch OpB, or ~OpB when Subtract=1, into a working B register;
  - carry <= Subtract; digit index <= 0; Busy <= 1; state <= RUN.
- RUN, each edge:
  - slice computes {c, s} = A[4i+3:4i] + B[4i+3:4i] + carry (5-bit result);
  - working result digit i <= s; carry <= c; index <= i+1;
  - on the last digit (i = NDIGITS-1), also capture c3, the carry into bit 3 of that digit.
- Completion, after the edge that processes digit NDIGITS-1 (edge E0+NDIGITS):
  - Result <= full working result, including the final digit;
  - Cout <= c; Overflow <= c3 XOR c;
  - Busy <= 0; Done <= 1; state <= IDLE.
- Done timing:
  - Done deasserts at the next edge unless another completion occurs.
  - Done is never high for more than one cycle per operation.
- Latency and throughput:
  - Start accepted at E0; Done visible for the cycle following E0+NDIGITS.
  - Busy is high for exactly NDIGITS cycles.
  - A Start in the Done cycle (Busy=0) is accepted: back-to-back throughput is one operation per NDIGITS+1 cycles.
- Start while Busy=1: ignored; operands and Subtract are not re-sampled.
- Output stability:
  - Result, Cout and Overflow hold their values from completion until the next completion or Reset.
  - They do not change during RUN.
  - Changing OpA/OpB/Subtract during RUN has no effect.
- Arithmetic:
  - modulo 2^W;
  - Cout = bit W of OpA + (Subtract ? ~OpB : OpB) + Subtract;
  - all digit arithmetic is 5-bit, with no truncation before the carry is extracted.
- NDIGITS=1: RUN lasts exactly one cycle; Overflow uses the carry into bit 3 of that single digit.

Test Plan:
- Addition, NDIGITS=4, Subtract=0:
  - 0x1234 + 0x0FCD -> Result=0x2201, Cout=0, Overflow=0.
  - Busy high for 4 cycles; Done one cycle, after edge E0+4.
- Subtraction, NDIGITS=4, Subtract=1:
  - 0x1234 - 0x1235 -> Result=0xFFFF, Cout=0, Overflow=0.
  - 0x8000 - 0x0001 -> Result=0x7FFF, Cout=1, Overflow=1.
- Signed and unsigned boundaries, NDIGITS=4:
  - 0x7FFF + 0x0001 -> 0x8000, Cout=0, Overflow=1.
  - 0xFFFF + 0x0001 -> 0x0000, Cout=1, Overflow=0.
- Handshake:
  - Start held high through RUN with OpA changed mid-run -> the first result is unaffected.
  - Start in the Done cycle starts a second operation; Done pulses after 5 and 10 cycles.
  - Result is unchanged during the second RUN.
- Reset mid-operation: assert Reset on the 2nd RUN cycle -> next cycle Busy=0, Done=0, Result=0, Cout=0, Overflow=0; no Done pulse follows.
- NDIGITS=1 instance, Subtract=1:
  - 0x9 - 0x7 -> Result=0x2, Cout=1, Overflow=1.
  - Busy high for 1 cycle.
